// File: rtl/monclk_reset_sequencer.sv
// monclk_reset_sequencer: waits for the clock monitor to report monclk present,
// requires it to stay present for STABLE_CYCLES, then releases NOUT reset
// outputs one at a time, STEP_CYCLES apart. It falls back to HOLD on loss of
// detection or on software request, and counts detection losses seen in RUN.
module monclk_reset_sequencer #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 256,
  parameter int STEP_CYCLES   = 16,
  parameter int NOUT          = 3
) (
  input  logic            reset,
  input  logic            monclk,
  input  logic            detected,
  input  logic            sw_reset,
  output logic [NOUT-1:0] rst_out,
  output logic            ready,
  output logic [7:0]      lost_cnt,
  output logic [1:0]      state
);

  localparam int MAX_CYC = (STABLE_CYCLES > STEP_CYCLES) ? STABLE_CYCLES : STEP_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam int IDX_W   = (NOUT > 1) ? $clog2(NOUT) : 1;

  // Reject parameter values the sequencer cannot honour.
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("monclk_reset_sequencer: SYNC_STAGES must be >= 2");
  end
  if (STABLE_CYCLES < 1) begin : g_bad_stable
    $error("monclk_reset_sequencer: STABLE_CYCLES must be >= 1");
  end
  if (STEP_CYCLES < 1) begin : g_bad_step
    $error("monclk_reset_sequencer: STEP_CYCLES must be >= 1");
  end
  if (NOUT < 1) begin : g_bad_nout
    $error("monclk_reset_sequencer: NOUT must be >= 1");
  end

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    STABLE  = 2'd1,
    RELEASE = 2'd2,
    RUN     = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   det_s;
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NOUT-1:0]        rst_q, rst_d;
  logic                   ready_q, ready_d;
  logic [7:0]             lost_q, lost_d;

  // Bring the refclk-domain detect flag into monclk; the only sampler of detected.
  always_ff @(posedge monclk or posedge reset) begin
    if (reset) begin
      sync_q <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], detected};
    end
  end

  assign det_s = sync_q[SYNC_STAGES-1];

  // State and output registers; reset forces all staged resets high immediately.
  always_ff @(posedge monclk or posedge reset) begin
    if (reset) begin
      state_q <= HOLD;
      cnt_q   <= {CNT_W{1'b0}};
      idx_q   <= {IDX_W{1'b0}};
      rst_q   <= {NOUT{1'b1}};
      ready_q <= 1'b0;
      lost_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rst_q   <= rst_d;
      ready_q <= ready_d;
      lost_q  <= lost_d;
    end
  end

  // Next-state and next-output logic; sw_reset and detection loss override the sequence.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rst_d   = rst_q;
    ready_d = ready_q;
    lost_d  = lost_q;

    // A loss while running is counted even if sw_reset arrives in the same cycle.
    if ((state_q == RUN) && !det_s && (lost_q != 8'hFF)) begin
      lost_d = lost_q + 8'd1;
    end else begin
      lost_d = lost_q;
    end

    if (sw_reset || ((state_q != HOLD) && !det_s)) begin
      state_d = HOLD;
      cnt_d   = {CNT_W{1'b0}};
      idx_d   = {IDX_W{1'b0}};
      rst_d   = {NOUT{1'b1}};
      ready_d = 1'b0;
    end else begin
      case (state_q)
        HOLD: begin
          cnt_d   = {CNT_W{1'b0}};
          idx_d   = {IDX_W{1'b0}};
          rst_d   = {NOUT{1'b1}};
          ready_d = 1'b0;
          if (det_s) begin
            state_d = STABLE;
          end else begin
            state_d = HOLD;
          end
        end
        STABLE: begin
          if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
            state_d = RELEASE;
            cnt_d   = {CNT_W{1'b0}};
            idx_d   = {IDX_W{1'b0}};
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        RELEASE: begin
          if (cnt_q == CNT_W'(STEP_CYCLES - 1)) begin
            cnt_d        = {CNT_W{1'b0}};
            rst_d[idx_q] = 1'b0;
            if (idx_q == IDX_W'(NOUT - 1)) begin
              state_d = RUN;
              rst_d   = {NOUT{1'b0}};
              ready_d = 1'b1;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        RUN: begin
          rst_d   = {NOUT{1'b0}};
          ready_d = 1'b1;
        end
        default: begin
          state_d = HOLD;
          cnt_d   = {CNT_W{1'b0}};
          idx_d   = {IDX_W{1'b0}};
          rst_d   = {NOUT{1'b1}};
          ready_d = 1'b0;
        end
      endcase
    end
  end

  assign rst_out  = rst_q;
  assign ready    = ready_q;
  assign lost_cnt = lost_q;
  assign state    = state_q;

endmodule

// File: doc/monclk_reset_sequencer.md
MONCLK_RESET_SEQUENCER -- requirements
Module: monclk_reset_sequencer

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer depth for detected; SHALL be >= 2.
REQ-002 Parameter STABLE_CYCLES, default 256: monclk cycles detected must stay high before release; SHALL be >= 1.
REQ-003 Parameter STEP_CYCLES, default 16: monclk cycles between successive staged reset releases; SHALL be >= 1.
REQ-004 Parameter NOUT, default 3: number of staged reset outputs; SHALL be >= 1.
REQ-005 Illegal parameter values SHALL cause an elaboration error.
REQ-006 reset  input  1  asynchronous, active-high, clears the whole block.
REQ-007 monclk  input  1  clock for all block logic.
REQ-008 detected  input  1  clock-present flag from the clock monitor (refclk domain); asynchronous to monclk.
REQ-009 sw_reset  input  1  monclk-synchronous, active-high request to re-run the sequence.
REQ-010 rst_out  output  NOUT  active-high staged resets for monclk-domain logic; bit 0 released first.
REQ-011 ready  output  1  high when all rst_out bits are released (state RUN).
REQ-012 lost_cnt  output  8  saturating count of detection losses that occurred in RUN.
REQ-013 state  output  2  FSM state code: HOLD=0, STABLE=1, RELEASE=2, RUN=3.

Function
REQ-014 detected SHALL pass through a SYNC_STAGES-flop monclk synchronizer; the result is det_s; no other logic SHALL sample detected.
REQ-015 All outputs SHALL be driven directly from flops; no combinational path from any input to any output.
REQ-016 HOLD: rst_out all ones, ready 0, counter 0; det_s=1 and sw_reset=0 -> STABLE with counter 0.
REQ-017 STABLE: counter increments by 1 each cycle; counter==STABLE_CYCLES-1 -> RELEASE with counter 0, stage index 0.
REQ-018 RELEASE: counter increments each cycle; on counter==STEP_CYCLES-1, rst_out[index] SHALL be cleared and the counter zeroed; if index==NOUT-1, go to RUN; otherwise increment index.
REQ-019 Released bits SHALL stay low for the rest of RELEASE; unreleased bits SHALL stay high.
REQ-020 RUN: rst_out all zeros and ready 1; ready SHALL rise on the same edge that clears rst_out[NOUT-1].
REQ-021 Timing: let edge E be the edge at which HOLD first samples det_s=1. rst_out[i] SHALL fall on edge E+STABLE_CYCLES+(i+1)*STEP_CYCLES. RUN and ready SHALL start on edge E+STABLE_CYCLES+NOUT*STEP_CYCLES.
REQ-022 det_s=0 in STABLE, RELEASE or RUN SHALL go to HOLD on the next edge: all rst_out bits set, ready cleared, counter and index zeroed.
REQ-023 sw_reset=1 in any state SHALL go to HOLD on the next edge; sw_reset has priority over every other transition.
REQ-024 lost_cnt SHALL increment by 1 on each RUN->HOLD transition caused by det_s=0, including when sw_reset is high in the same cycle; it SHALL saturate at 255.
REQ-025 sw_reset-only exits from RUN, and losses in STABLE or RELEASE, SHALL NOT change lost_cnt.
REQ-026 With sw_reset held high the FSM SHALL remain in HOLD; the sequence restarts from REQ-016 after it is removed.
REQ-027 Counter width SHALL be clog2(max(STABLE_CYCLES,STEP_CYCLES)+1); the index width SHALL be clog2(NOUT) with a minimum of 1; counters SHALL never wrap.
REQ-028 NOUT=1 SHALL be supported: a single release step, then RUN.

Reset
REQ-029 reset SHALL assert rst_out to all ones asynchronously, without waiting for a monclk edge.
REQ-030 On reset: state HOLD, ready 0, lost_cnt 0, counters 0, synchronizer flops 0; initial values SHALL match.
REQ-031 Every rst_out deassertion SHALL be synchronous to monclk.
REQ-032 Reset asserted mid-sequence SHALL abort it; after release the FSM SHALL start from HOLD.

Verification (SYNC_STAGES=2, STABLE_CYCLES=8, STEP_CYCLES=4, NOUT=3)
REQ-033 detected held 1 from reset release -> rst_out=3'b111 until edge E+11; 3'b110 at E+12, 3'b100 at E+16, 3'b000 and ready=1 at E+20.
REQ-034 detected drops in RUN for 3 cycles -> HOLD, rst_out=3'b111, ready=0, lost_cnt=1; full sequence repeats after detected returns.
REQ-035 detected drops to 0 at STABLE counter=5 -> HOLD; lost_cnt stays 0; counter restarts from 0.
REQ-036 sw_reset pulses 1 cycle in RUN -> HOLD, lost_cnt unchanged, re-sequence completes 20 edges after HOLD resamples det_s=1.
REQ-037 300 detection losses in RUN -> lost_cnt=255 and holds there.
REQ-038 reset asserted mid-RELEASE with monclk stopped -> rst_out=3'b111 immediately, ready=0, lost_cnt=0.
